sram_port_arb: RTL and testbench

Two-requester round-robin arbiter that shares one 8-bit SRAM (separate write and read address ports, registered read data) between two cores. Each requester sees a simple req/gnt beat interface. The SRAM side has the same o_waddr/o_wdata/o_wen/o_raddr/i_rdata port shape that a core's register-file/memory adapter drives. The block sits between two such adapters and the single SRAM macro, letting two cores in a tile share one memory.

---
 rtl/sram_port_arb_if.sv | 33 +++
 rtl/sram_port_arb.sv | 137 +++++++++++++
 tb/tb_sram_port_arb.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arb_if.sv
// sram_port_arb_if: requester beat signals plus the SRAM-side port of the
// two-requester SRAM arbiter. Signal names match the legacy flat port list.
interface sram_port_arb_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic [1:0]    i_req;
  logic [1:0]    i_we;
  logic [AW-1:0] i_addr0;
  logic [AW-1:0] i_addr1;
  logic [DW-1:0] i_wdata0;
  logic [DW-1:0] i_wdata1;
  logic [1:0]    o_gnt;
  logic [1:0]    o_rvalid;
  logic [DW-1:0] o_rdata;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;
  logic          o_wen;
  logic [AW-1:0] o_raddr;
  logic [DW-1:0] i_rdata;

  // Arbiter side.
  modport slave (
    input  i_req, i_we, i_addr0, i_addr1, i_wdata0, i_wdata1, i_rdata,
    output o_gnt, o_rvalid, o_rdata, o_waddr, o_wdata, o_wen, o_raddr
  );

  // Requesters plus SRAM macro side.
  modport master (
    output i_req, i_we, i_addr0, i_addr1, i_wdata0, i_wdata1, i_rdata,
    input  o_gnt, o_rvalid, o_rdata, o_waddr, o_wdata, o_wen, o_raddr
  );
endinterface

// File: rtl/sram_port_arb.sv
// sram_port_arb: round-robin arbiter sharing one SRAM (separate write/read
// address ports, registered read data) between two req/gnt requesters.
// Optional feature: define SRAM_ARB_BURST_LIMIT_EN to force a hand-over after
// MAX_BURST consecutive beats while the other requester is waiting.
module sram_port_arb #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input logic           i_clk,
  input logic           i_rst_n,
  sram_port_arb_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          rr;
  logic          owner;
  logic          beat;
  logic          beat_we;
  logic [AW-1:0] beat_addr;
  logic [DW-1:0] beat_wdata;
  logic          at_limit;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;
  logic [AW-1:0] raddr_q;
  logic          tag_v;
  logic          tag_own;

  // Beat decode and current-owner mux of the requester beat fields.
  always_comb begin
    owner      = (state == OWN1);
    beat       = ((state == OWN0) && bus.i_req[0]) || ((state == OWN1) && bus.i_req[1]);
    beat_we    = owner ? bus.i_we[1]    : bus.i_we[0];
    beat_addr  = owner ? bus.i_addr1    : bus.i_addr0;
    beat_wdata = owner ? bus.i_wdata1   : bus.i_wdata0;
  end

`ifdef SRAM_ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt;

  // The MAX_BURST-th beat of a tenure is the limit beat.
  always_comb begin
    at_limit = beat && (cnt == CW'(MAX_BURST - 1));
  end

  // Beat counter: clears on ownership entry and wraps at the limit beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      cnt <= '0;
    end else if (beat) begin
      cnt <= at_limit ? '0 : cnt + CW'(1);
    end
  end
`else
  // Without the limit the owner keeps the grant until it drops its request.
  always_comb begin
    at_limit = 1'b0;
  end
`endif

  // Ownership next-state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.i_req == 2'b11)  state_nxt = rr ? OWN1 : OWN0;
        else if (bus.i_req[0])   state_nxt = OWN0;
        else if (bus.i_req[1])   state_nxt = OWN1;
        else                     state_nxt = IDLE;
      end
      OWN0: begin
        if (!bus.i_req[0])                state_nxt = bus.i_req[1] ? OWN1 : IDLE;
        else if (at_limit && bus.i_req[1]) state_nxt = OWN1;
        else                              state_nxt = OWN0;
      end
      OWN1: begin
        if (!bus.i_req[1])                state_nxt = bus.i_req[0] ? OWN0 : IDLE;
        else if (at_limit && bus.i_req[0]) state_nxt = OWN0;
        else                              state_nxt = OWN1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; the round-robin pointer favours the other side on entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      rr    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        if (state_nxt == OWN0) rr <= 1'b1;
        if (state_nxt == OWN1) rr <= 1'b0;
      end
    end
  end

  // Held SRAM address/data values and the read-return tag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      waddr_q <= '0;
      wdata_q <= '0;
      raddr_q <= '0;
      tag_v   <= 1'b0;
      tag_own <= 1'b0;
    end else begin
      if (beat && beat_we) begin
        waddr_q <= beat_addr;
        wdata_q <= beat_wdata;
      end
      if (beat && !beat_we) raddr_q <= beat_addr;
      tag_v   <= beat && !beat_we;
      tag_own <= owner;
    end
  end

  // SRAM outputs pass the beat fields through combinationally and hold otherwise.
  always_comb begin
    bus.o_gnt    = {state == OWN1, state == OWN0};
    bus.o_wen    = beat && beat_we;
    bus.o_waddr  = (beat && beat_we)  ? beat_addr  : waddr_q;
    bus.o_wdata  = (beat && beat_we)  ? beat_wdata : wdata_q;
    bus.o_raddr  = (beat && !beat_we) ? beat_addr  : raddr_q;
    bus.o_rvalid = {tag_v && tag_own, tag_v && !tag_own};
    bus.o_rdata  = bus.i_rdata;
  end

endmodule

// File: tb/tb_sram_port_arb.sv
// tb_sram_port_arb: randomized and directed bench for sram_port_arb with a
// behavioural SRAM and an ownership/shadow-memory reference model.
// Honours SRAM_ARB_BURST_LIMIT_EN the same way as the design.
module tb_sram_port_arb;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_port_arb_if #(.AW(AW), .DW(DW)) bus ();

  sram_port_arb #(.AW(AW), .DW(DW), .MAX_BURST(MB)) u_dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  // SRAM macro: synchronous write, registered read.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (bus.o_wen) mem[bus.o_waddr] <= bus.o_wdata;
    bus.i_rdata <= mem[bus.o_raddr];
  end

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state.
  int            m_own;     // -1 idle, else owning requester
  bit            m_rr;
  int            m_beats;
  bit            pv;
  int            pwho;
  logic [DW-1:0] pdata;
  bit            pknown;
  logic [AW-1:0] m_waddr, m_raddr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] shadow [256];
  bit            known  [256];

  task automatic model_reset();
    m_own = -1; m_rr = 1'b0; m_beats = 0; pv = 1'b0; pwho = 0; pknown = 1'b0;
    pdata = '0; m_waddr = '0; m_raddr = '0; m_wdata = '0;
  endtask

  // One clock cycle: drive, check against model at negedge, advance model.
  task automatic step(input logic [1:0] req, input logic [1:0] we,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      output logic [1:0] g, output logic [1:0] rv,
                      output logic [DW-1:0] rd);
    logic [1:0]    e_gnt, e_rv;
    logic          beat, bwe;
    logic [AW-1:0] ba, e_waddr, e_raddr;
    logic [DW-1:0] bd, e_wdata;
    int            n, k;
    bus.i_req = req; bus.i_we = we; bus.i_addr0 = a0; bus.i_addr1 = a1;
    bus.i_wdata0 = d0; bus.i_wdata1 = d1;
    @(negedge clk);
    e_gnt   = (m_own == 0) ? 2'b01 : (m_own == 1) ? 2'b10 : 2'b00;
    beat    = (m_own >= 0) && req[m_own];
    bwe     = beat && we[m_own];
    ba      = (m_own == 1) ? a1 : a0;
    bd      = (m_own == 1) ? d1 : d0;
    e_waddr = bwe ? ba : m_waddr;
    e_wdata = bwe ? bd : m_wdata;
    e_raddr = (beat && !bwe) ? ba : m_raddr;
    e_rv    = pv ? (pwho == 1 ? 2'b10 : 2'b01) : 2'b00;
    n_cmp++; if (bus.o_gnt !== e_gnt) begin n_fail++; $display("FAIL gnt: got %b want %b @%0t", bus.o_gnt, e_gnt, $time); end
    n_cmp++; if (bus.o_wen !== bwe) begin n_fail++; $display("FAIL wen: got %b want %b @%0t", bus.o_wen, bwe, $time); end
    n_cmp++; if (bus.o_waddr !== e_waddr) begin n_fail++; $display("FAIL waddr: got %h want %h @%0t", bus.o_waddr, e_waddr, $time); end
    n_cmp++; if (bus.o_wdata !== e_wdata) begin n_fail++; $display("FAIL wdata: got %h want %h @%0t", bus.o_wdata, e_wdata, $time); end
    n_cmp++; if (bus.o_raddr !== e_raddr) begin n_fail++; $display("FAIL raddr: got %h want %h @%0t", bus.o_raddr, e_raddr, $time); end
    n_cmp++; if (bus.o_rvalid !== e_rv) begin n_fail++; $display("FAIL rvalid: got %b want %b @%0t", bus.o_rvalid, e_rv, $time); end
    if (pv && pknown) begin
      n_cmp++; if (bus.o_rdata !== pdata) begin n_fail++; $display("FAIL rdata: got %h want %h @%0t", bus.o_rdata, pdata, $time); end
    end
    g = bus.o_gnt; rv = bus.o_rvalid; rd = bus.o_rdata;
    // Advance the model for the coming edge.
    m_waddr = e_waddr; m_wdata = e_wdata; m_raddr = e_raddr;
    if (bwe) begin shadow[ba] = bd; known[ba] = 1'b1; end
    pv = beat && !bwe; pwho = m_own; pdata = shadow[ba]; pknown = known[ba];
    if (m_own < 0) begin
      if (req == 2'b11) n = m_rr ? 1 : 0;
      else if (req[0])  n = 0;
      else if (req[1])  n = 1;
      else              n = -1;
    end else begin
      k = m_own;
      if (!req[k]) n = req[1-k] ? 1 - k : -1;
      else begin
        n = k;
        m_beats++;
`ifdef SRAM_ARB_BURST_LIMIT_EN
        if (m_beats == MB) begin
          if (req[1-k]) n = 1 - k;
          else m_beats = 0;
        end
`endif
      end
    end
    if (n != m_own && n >= 0) begin m_rr = (n == 0); m_beats = 0; end
    m_own = n;
    @(posedge clk); #1;
  endtask

  logic [1:0] g, rv;
  logic [DW-1:0] rd;

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 2'b00, '0, '0, '0, '0, g, rv, rd);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.i_req = 2'b11; bus.i_we = 2'b11;
    bus.i_addr0 = 8'h33; bus.i_addr1 = 8'h44; bus.i_wdata0 = 8'h55; bus.i_wdata1 = 8'h66;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.o_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", bus.o_gnt); end
    n_cmp++; if (bus.o_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b want 0", bus.o_wen); end
    n_cmp++; if (bus.o_rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b want 00", bus.o_rvalid); end
    n_cmp++; if (bus.o_waddr !== 8'h00 || bus.o_raddr !== 8'h00 || bus.o_wdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_addr: got %h/%h/%h want 00/00/00", bus.o_waddr, bus.o_raddr, bus.o_wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; model_reset();
    step(2'b11, 2'b00, 8'h01, 8'h02, '0, '0, g, rv, rd);
    step(2'b11, 2'b00, 8'h01, 8'h02, '0, '0, g, rv, rd);
    n_cmp++; if (g !== 2'b01) begin n_fail++; $display("FAIL reset_first_gnt: got %b want 01", g); end
    idle_cycles(2);
  endtask

  task automatic test_write_read();
    step(2'b01, 2'b01, 8'h10, '0, 8'hA5, '0, g, rv, rd);
    step(2'b01, 2'b01, 8'h10, '0, 8'hA5, '0, g, rv, rd);
    step(2'b01, 2'b00, 8'h10, '0, 8'h00, '0, g, rv, rd);
    step(2'b00, 2'b00, '0, '0, '0, '0, g, rv, rd);
    n_cmp++; if (rv !== 2'b01 || rd !== 8'hA5) begin n_fail++; $display("FAIL write_read: got rv=%b rd=%h want 01/a5", rv, rd); end
    idle_cycles(1);
  endtask

  task automatic test_handover_read();
    step(2'b01, 2'b01, 8'h20, '0, 8'h3C, '0, g, rv, rd);
    step(2'b01, 2'b01, 8'h20, '0, 8'h3C, '0, g, rv, rd);
    step(2'b11, 2'b00, 8'h20, 8'h05, '0, '0, g, rv, rd);
    step(2'b10, 2'b00, '0, 8'h05, '0, '0, g, rv, rd);
    n_cmp++; if (rv !== 2'b01 || rd !== 8'h3C) begin n_fail++; $display("FAIL handover_read: got rv=%b rd=%h want 01/3c", rv, rd); end
    step(2'b10, 2'b00, '0, 8'h05, '0, '0, g, rv, rd);
    n_cmp++; if (g !== 2'b10 || rv !== 2'b00) begin n_fail++; $display("FAIL handover_gnt: got g=%b rv=%b want 10/00", g, rv); end
    idle_cycles(3);
  endtask

  task automatic test_contention();
    int beats [2];
    bit drop [2];
    int seq [$];
    logic [1:0] req;
    logic [1:0] prev_g;
    beats[0] = 0; beats[1] = 0; drop[0] = 0; drop[1] = 0; prev_g = 2'b00;
    for (int c = 0; c < 40; c++) begin
      req = {~drop[1], ~drop[0]};
      step(req, {c[0], c[1]}, 8'(c), 8'(c + 64), 8'($urandom), 8'($urandom), g, rv, rd);
      if (g != 2'b00 && g != prev_g) seq.push_back(g == 2'b10 ? 1 : 0);
      prev_g = g;
      for (int k = 0; k < 2; k++) begin
        if (drop[k]) drop[k] = 1'b0;
        else if (g[k] && req[k]) begin
          beats[k]++;
          if (beats[k] == 3) begin beats[k] = 0; drop[k] = 1'b1; end
        end
      end
    end
    n_cmp++; if (seq.size() < 4) begin n_fail++; $display("FAIL contention_tenures: got %0d want >=4", seq.size()); end
    for (int i = 1; i < seq.size(); i++) begin
      n_cmp++; if (seq[i] == seq[i-1]) begin n_fail++; $display("FAIL contention_alt: tenure %0d got %0d want %0d", i, seq[i], 1 - seq[i-1]); end
    end
    idle_cycles(3);
  endtask

  task automatic test_burst();
    int run;
    bit stop;
    int want;
    // Requester 1 waiting.
    step(2'b01, 2'b00, 8'h01, 8'h02, '0, '0, g, rv, rd);
    run = 0; stop = 0;
    for (int c = 0; c < 12; c++) begin
      step(2'b11, 2'b11, 8'(c), 8'h80, 8'(c), 8'h11, g, rv, rd);
      if (!stop && g == 2'b01) run++; else stop = 1;
    end
`ifdef SRAM_ARB_BURST_LIMIT_EN
    want = MB;
`else
    want = 12;
`endif
    n_cmp++; if (run != want) begin n_fail++; $display("FAIL burst_wait: got %0d beats want %0d", run, want); end
    idle_cycles(3);
    // Requester 1 idle.
    step(2'b01, 2'b00, 8'h01, '0, '0, '0, g, rv, rd);
    run = 0;
    for (int c = 0; c < 10; c++) begin
      step(2'b01, 2'b01, 8'(c + 8'h90), '0, 8'(c), '0, g, rv, rd);
      if (g == 2'b01) run++;
    end
    n_cmp++; if (run != 10) begin n_fail++; $display("FAIL burst_alone: got %0d beats want 10", run); end
    idle_cycles(2);
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      step(2'($urandom), 2'($urandom), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
           8'($urandom), 8'($urandom), g, rv, rd);
    end
    idle_cycles(2);
  endtask

  task automatic test_async_reset();
    step(2'b01, 2'b01, 8'h40, '0, 8'h77, '0, g, rv, rd);
    step(2'b01, 2'b01, 8'h40, '0, 8'h77, '0, g, rv, rd);
    step(2'b01, 2'b00, 8'h40, '0, '0, '0, g, rv, rd);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.o_rvalid !== 2'b00 || bus.o_gnt !== 2'b00) begin
      n_fail++; $display("FAIL async_reset: got rv=%b g=%b want 00/00", bus.o_rvalid, bus.o_gnt);
    end
    model_reset();
    bus.i_req = 2'b11;
    @(negedge clk);
    n_cmp++; if (bus.o_rvalid !== 2'b00) begin n_fail++; $display("FAIL async_reset_hold: got rv=%b want 00", bus.o_rvalid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(2'b11, 2'b00, 8'h41, 8'h42, '0, '0, g, rv, rd);
    step(2'b11, 2'b00, 8'h41, 8'h42, '0, '0, g, rv, rd);
    n_cmp++; if (g !== 2'b01) begin n_fail++; $display("FAIL async_reset_first_gnt: got %b want 01", g); end
    idle_cycles(2);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin shadow[i] = '0; known[i] = 1'b0; end
    model_reset();
    test_reset();
    test_write_read();
    test_handover_read();
    test_contention();
    test_burst();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
